// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the ALU: register file with writeback bypass,
// immediate/negate operand shaping, busy scoreboard and a one-deep output register.
module alu_operand_stage #(
   parameter int WIDTH    = 8,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [2:0]        IN_ALUOP,
   input  logic [ADDR_W-1:0] IN_SRC1,
   input  logic [ADDR_W-1:0] IN_SRC2,
   input  logic [ADDR_W-1:0] IN_DEST,
   input  logic              IN_WE,
   input  logic [WIDTH-1:0]  IN_IMM,
   input  logic              IN_IMM_SEL,
   input  logic              IN_NEG,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [WIDTH-1:0]  DATA1,
   output logic [WIDTH-1:0]  DATA2,
   output logic [2:0]        SELECT,
   output logic [ADDR_W-1:0] OUT_DEST,
   output logic              OUT_WE,
   input  logic              WB_EN,
   input  logic [ADDR_W-1:0] WB_ADDR,
   input  logic [WIDTH-1:0]  WB_DATA
);

   logic [WIDTH-1:0]    regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;

   logic [WIDTH-1:0] rd1;
   logic [WIDTH-1:0] rd2;
   logic [WIDTH-1:0] op2;
   logic [WIDTH-1:0] op2_final;
   logic             pend1;
   logic             pend2;
   logic             pend_dest;
   logic             hazard;
   logic             accept;

   // Source reads; a same-cycle writeback is forwarded so the result is never a cycle stale.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      rd1 = regs[IN_SRC1];
      rd2 = regs[IN_SRC2];
      if (WB_EN && (WB_ADDR == IN_SRC1)) rd1 = WB_DATA;
      if (WB_EN && (WB_ADDR == IN_SRC2)) rd2 = WB_DATA;
   end

   // Negation happens after the immediate mux, so SUB-immediate works the same way.
   assign op2       = IN_IMM_SEL ? IN_IMM : rd2;
   assign op2_final = IN_NEG ? (~op2 + WIDTH'(1)) : op2;

   // A register retiring this cycle no longer blocks its readers or writers.
   assign pend1     = busy[IN_SRC1] && !(WB_EN && (WB_ADDR == IN_SRC1));
   assign pend2     = busy[IN_SRC2] && !(WB_EN && (WB_ADDR == IN_SRC2));
   assign pend_dest = busy[IN_DEST] && !(WB_EN && (WB_ADDR == IN_DEST));
   assign hazard    = pend1 || (!IN_IMM_SEL && pend2) || (IN_WE && pend_dest);

   assign IN_READY  = (!OUT_VALID || OUT_READY) && !hazard;
   assign accept    = IN_VALID && IN_READY;

   // Clear on writeback first, then set on issue, so a same-edge set wins.
   always_comb begin
      busy_nxt = busy;
      if (WB_EN)           busy_nxt[WB_ADDR] = 1'b0;
      if (accept && IN_WE) busy_nxt[IN_DEST] = 1'b1;
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         // NOTE: the register file is reset here because architectural state must read 0 after reset.
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
         if (WB_EN) regs[WB_ADDR] <= WB_DATA;
         busy <= busy_nxt;
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         OUT_VALID <= 1'b0;
         DATA1     <= '0;
         DATA2     <= '0;
         SELECT    <= '0;
         OUT_DEST  <= '0;
         OUT_WE    <= 1'b0;
      end else if (accept) begin
         OUT_VALID <= 1'b1;
         DATA1     <= rd1;
         DATA2     <= op2_final;
         SELECT    <= IN_ALUOP;
         OUT_DEST  <= IN_DEST;
         OUT_WE    <= IN_WE;
      end else if (OUT_READY) begin
         // Payload holds its last value once consumed; only the valid flag drops.
         OUT_VALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: operand table plus hand-written
// stall, bypass, scoreboard and reset sequences.
module tb_alu_operand_stage;

   logic       CLK = 1'b0;
   logic       RESETN;
   logic       IN_VALID;
   logic       IN_READY;
   logic [2:0] IN_ALUOP;
   logic [2:0] IN_SRC1;
   logic [2:0] IN_SRC2;
   logic [2:0] IN_DEST;
   logic       IN_WE;
   logic [7:0] IN_IMM;
   logic       IN_IMM_SEL;
   logic       IN_NEG;
   logic       OUT_VALID;
   logic       OUT_READY;
   logic [7:0] DATA1;
   logic [7:0] DATA2;
   logic [2:0] SELECT;
   logic [2:0] OUT_DEST;
   logic       OUT_WE;
   logic       WB_EN;
   logic [2:0] WB_ADDR;
   logic [7:0] WB_DATA;

   int n_tests = 0;
   int n_fail  = 0;

   alu_operand_stage #(.WIDTH(8), .NUM_REGS(8), .ADDR_W(3)) dut (
      .CLK(CLK), .RESETN(RESETN),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_ALUOP(IN_ALUOP),
      .IN_SRC1(IN_SRC1), .IN_SRC2(IN_SRC2), .IN_DEST(IN_DEST), .IN_WE(IN_WE),
      .IN_IMM(IN_IMM), .IN_IMM_SEL(IN_IMM_SEL), .IN_NEG(IN_NEG),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT),
      .OUT_DEST(OUT_DEST), .OUT_WE(OUT_WE),
      .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [2:0] aluop;
      logic [2:0] src1;
      logic [2:0] src2;
      logic [7:0] imm;
      logic       imm_sel;
      logic       neg;
      logic [7:0] exp_d1;
      logic [7:0] exp_d2;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one rising edge and settle 1ns past it before sampling.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic v, input logic [2:0] op, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [2:0] d, input logic we,
                        input logic [7:0] imm, input logic isel, input logic neg);
      IN_VALID = v; IN_ALUOP = op; IN_SRC1 = s1; IN_SRC2 = s2; IN_DEST = d;
      IN_WE = we; IN_IMM = imm; IN_IMM_SEL = isel; IN_NEG = neg;
   endtask

   task automatic wb(input logic en, input logic [2:0] a, input logic [7:0] d);
      WB_EN = en; WB_ADDR = a; WB_DATA = d;
   endtask

   initial begin
      // r0..r7 are preloaded to 00 05 03 7F 80 FF 01 C4 before the table runs.
      vecs[0] = '{3'd1, 3'd1, 3'd2, 8'h00, 1'b0, 1'b1, 8'h05, 8'hFD};
      vecs[1] = '{3'd2, 3'd3, 3'd4, 8'h00, 1'b0, 1'b0, 8'h7F, 8'h80};
      vecs[2] = '{3'd3, 3'd4, 3'd4, 8'h00, 1'b0, 1'b1, 8'h80, 8'h80};
      vecs[3] = '{3'd4, 3'd5, 3'd6, 8'h00, 1'b0, 1'b1, 8'hFF, 8'hFF};
      vecs[4] = '{3'd5, 3'd7, 3'd5, 8'h00, 1'b0, 1'b1, 8'hC4, 8'h01};
      vecs[5] = '{3'd6, 3'd0, 3'd3, 8'h5A, 1'b1, 1'b0, 8'h00, 8'h5A};
      vecs[6] = '{3'd7, 3'd2, 3'd1, 8'h00, 1'b1, 1'b1, 8'h03, 8'h00};
      vecs[7] = '{3'd0, 3'd6, 3'd3, 8'h00, 1'b0, 1'b1, 8'h01, 8'h81};
      vecs[8] = '{3'd1, 3'd7, 3'd0, 8'h00, 1'b0, 1'b1, 8'hC4, 8'h00};

      RESETN = 1'b0; OUT_READY = 1'b1;
      issue(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
      wb(0, 0, 8'h00);
      tick(); tick();
      check("reset_out_valid", OUT_VALID, 0);
      check("reset_data1", DATA1, 0);
      check("reset_data2", DATA2, 0);
      check("reset_select", SELECT, 0);
      check("reset_out_we", OUT_WE, 0);
      RESETN = 1'b1;

      // Reset while an operation is in flight and r2 is busy.
      wb(1, 3'd2, 8'h77);
      tick();
      wb(0, 0, 8'h00);
      OUT_READY = 1'b0;
      issue(1, 3'd5, 3'd2, 3'd2, 3'd2, 1, 8'h00, 0, 0);
      tick();
      issue(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
      check("midop_valid", OUT_VALID, 1);
      check("midop_data1", DATA1, 8'h77);
      check("midop_dest", OUT_DEST, 3'd2);
      #2 RESETN = 1'b0;
      #1;
      check("async_rst_valid", OUT_VALID, 0);
      check("async_rst_data1", DATA1, 0);
      check("async_rst_dest", OUT_DEST, 0);
      check("async_rst_we", OUT_WE, 0);
      tick();
      RESETN = 1'b1;
      OUT_READY = 1'b1;
      issue(1, 3'd0, 3'd2, 3'd2, 3'd2, 1, 8'h00, 0, 0);
      #1 check("rst_busy_cleared", IN_READY, 1);
      tick();
      check("rst_reg_zero", DATA1, 0);
      issue(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
      wb(1, 3'd2, 8'h00);
      tick();

      // Preload, then apply the operand table back-to-back.
      wb(1, 3'd1, 8'h05); tick();
      wb(1, 3'd2, 8'h03); tick();
      wb(1, 3'd3, 8'h7F); tick();
      wb(1, 3'd4, 8'h80); tick();
      wb(1, 3'd5, 8'hFF); tick();
      wb(1, 3'd6, 8'h01); tick();
      wb(1, 3'd7, 8'hC4); tick();
      wb(0, 0, 8'h00);
      for (int i = 0; i < 9; i++) begin
         issue(1, vecs[i].aluop, vecs[i].src1, vecs[i].src2, 3'd0, 0,
               vecs[i].imm, vecs[i].imm_sel, vecs[i].neg);
         tick();
         check($sformatf("vec%0d_valid", i), OUT_VALID, 1);
         check($sformatf("vec%0d_data1", i), DATA1, vecs[i].exp_d1);
         check($sformatf("vec%0d_data2", i), DATA2, vecs[i].exp_d2);
         check($sformatf("vec%0d_select", i), SELECT, vecs[i].aluop);
      end

      // RAW stall on r3 released by a writeback that is bypassed into DATA1.
      issue(1, 3'd2, 3'd0, 3'd0, 3'd3, 1, 8'h00, 0, 0);
      tick();
      check("raw_issue_we", OUT_WE, 1);
      check("raw_issue_dest", OUT_DEST, 3'd3);
      issue(1, 3'd3, 3'd3, 3'd0, 3'd0, 0, 8'h00, 0, 0);
      #1 check("raw_stall_0", IN_READY, 0);
      tick();
      check("raw_stall_1", IN_READY, 0);
      check("raw_bubble", OUT_VALID, 0);
      wb(1, 3'd3, 8'h2A);
      #1 check("raw_release", IN_READY, 1);
      tick();
      wb(0, 0, 8'h00);
      check("raw_bypass_data1", DATA1, 8'h2A);
      check("raw_bypass_valid", OUT_VALID, 1);

      // Backpressure holds outputs, then resumes with no bubble.
      issue(1, 3'd3, 3'd1, 3'd2, 3'd0, 0, 8'h00, 0, 0);
      tick();
      OUT_READY = 1'b0;
      issue(1, 3'd4, 3'd3, 3'd1, 3'd0, 0, 8'h00, 0, 0);
      for (int c = 0; c < 3; c++) begin
         #1 check($sformatf("bp%0d_in_ready", c), IN_READY, 0);
         tick();
         check($sformatf("bp%0d_data1", c), DATA1, 8'h05);
         check($sformatf("bp%0d_data2", c), DATA2, 8'h03);
         check($sformatf("bp%0d_select", c), SELECT, 3'd3);
         check($sformatf("bp%0d_valid", c), OUT_VALID, 1);
      end
      OUT_READY = 1'b1;
      #1 check("bp_resume_ready", IN_READY, 1);
      tick();
      check("bp_next_valid", OUT_VALID, 1);
      check("bp_next_data1", DATA1, 8'h2A);
      check("bp_next_data2", DATA2, 8'h05);
      check("bp_next_select", SELECT, 3'd4);
      issue(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
      tick();
      check("drain_valid", OUT_VALID, 0);
      check("drain_hold_data1", DATA1, 8'h2A);

      // Immediate operand bypasses a busy SRC2; negation boundary values.
      issue(1, 3'd0, 3'd0, 3'd0, 3'd5, 1, 8'h00, 0, 0);
      tick();
      issue(1, 3'd1, 3'd1, 3'd5, 3'd0, 0, 8'h80, 1, 1);
      #1 check("imm_no_stall", IN_READY, 1);
      tick();
      check("imm_neg_80", DATA2, 8'h80);
      issue(1, 3'd1, 3'd1, 3'd5, 3'd0, 0, 8'h00, 1, 1);
      tick();
      check("imm_neg_00", DATA2, 8'h00);
      issue(1, 3'd1, 3'd1, 3'd5, 3'd0, 0, 8'h00, 0, 0);
      #1 check("src2_busy_stall", IN_READY, 0);
      wb(1, 3'd5, 8'hFF);
      tick();
      wb(0, 0, 8'h00);

      // Same-edge writeback and issue to r4: the set wins.
      wb(1, 3'd4, 8'h80);
      issue(1, 3'd2, 3'd0, 3'd0, 3'd4, 1, 8'h00, 0, 0);
      #1 check("same_edge_accept", IN_READY, 1);
      tick();
      wb(0, 0, 8'h00);
      issue(1, 3'd2, 3'd4, 3'd0, 3'd0, 0, 8'h00, 0, 0);
      #1 check("same_edge_r4_stall", IN_READY, 0);
      issue(1, 3'd2, 3'd0, 3'd0, 3'd4, 1, 8'h00, 0, 0);
      #1 check("waw_dest_stall", IN_READY, 0);
      issue(1, 3'd2, 3'd4, 3'd0, 3'd0, 0, 8'h00, 0, 0);
      wb(1, 3'd4, 8'h3C);
      tick();
      wb(0, 0, 8'h00);
      check("r4_release_data1", DATA1, 8'h3C);
      issue(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
